dut_pipe: RTL and testbench

- Registered, elastic successor to the combinational smoke-test DUT.
- Carries the same four field types through a DEPTH-stage valid/ready pipeline:
  - scalar bit
  - unpacked bit bus
  - signed word
  - unpacked array of signed words
- Applies a per-beat transform mode and keeps a beat counter and a sticky saturation flag.
- Sits between the bench driver and monitor as the reference data path for smoke and throughput testing.

---
 rtl/dut_pkg.sv | 35 +++
 rtl/dut_pipe_stage.sv | 33 +++
 rtl/dut_pipe.sv | 139 +++++++++++++
 tb/tb_dut_pipe.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_pkg.sv
// Shared types and helpers for the dut_pipe data path.
package dut_pkg;

   typedef enum logic [1:0] {
      PASS = 2'b00,
      INV  = 2'b01,
      NEG  = 2'b10,
      REV  = 2'b11
   } mode_e;

   localparam int unsigned DEPTH_MIN = 1;
   localparam int unsigned DEPTH_MAX = 8;

   // Widest signed word sat_neg can handle; callers sign-extend into it.
   localparam int unsigned WORD_MAX = 32;

   typedef struct packed {
      logic                       sat;
      logic signed [WORD_MAX-1:0] val;
   } neg_t;

   // Negate a width-bit signed value held sign-extended in a WORD_MAX word.
   // The most negative value cannot be negated, so it clamps to the most positive.
   function automatic neg_t sat_neg(input logic signed [WORD_MAX-1:0] x,
                                    input int unsigned width);
      neg_t                       r;
      logic signed [WORD_MAX-1:0] most_neg;
      most_neg = '1;
      most_neg = most_neg << (width - 1);
      r.sat    = (x == most_neg);
      r.val    = r.sat ? ~most_neg : -x;
      return r;
   endfunction

endpackage

// File: rtl/dut_pipe_stage.sv
// One valid/ready register slice carrying an opaque packed beat.
module dut_pipe_stage
   import dut_pkg::*;
#(
   parameter type beat_t = logic
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  up_valid,
   input  beat_t up_data,
   output logic  up_ready,
   output logic  dn_valid,
   output beat_t dn_data,
   input  logic  dn_ready
);

   // The slice accepts when empty or when its current beat leaves on this edge.
   assign up_ready = !dn_valid || dn_ready;

   // Data loads only with a valid beat, so the held beat survives a drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
      end else if (up_ready) begin
         dn_valid <= up_valid;
         if (up_valid) begin
            dn_data <= up_data;
         end
      end
   end

endmodule

// File: rtl/dut_pipe.sv
// Elastic DEPTH-stage pipeline applying a per-beat transform, with a beat
// counter and a sticky saturation flag.
module dut_pipe
   import dut_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned BUS_WIDTH  = 2,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   mode,
   input  logic                         in1,
   input  logic                         in2 [BUS_WIDTH],
   input  logic signed [DATA_WIDTH-1:0] in3,
   input  logic signed [DATA_WIDTH-1:0] in4 [BUS_WIDTH],
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out1,
   output logic                         out2 [BUS_WIDTH],
   output logic signed [DATA_WIDTH-1:0] out3,
   output logic signed [DATA_WIDTH-1:0] out4 [BUS_WIDTH],
   output logic [CNT_WIDTH-1:0]         beat_cnt,
   output logic                         sat_flag
);

   if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_chk
      $error("dut_pipe: DEPTH out of range");
   end
   if (DATA_WIDTH > WORD_MAX) begin : g_width_chk
      $error("dut_pipe: DATA_WIDTH too wide for sat_neg");
   end

   typedef struct packed {
      logic                                 b1;
      logic [BUS_WIDTH-1:0]                 b2;
      logic signed [DATA_WIDTH-1:0]         w3;
      logic [BUS_WIDTH-1:0][DATA_WIDTH-1:0] w4;
   } beat_t;

   beat_t xf;
   logic  xf_sat;
   neg_t  n;

   // Transform the incoming beat; mode is consumed here and never stored.
   always_comb begin
      n      = '0;
      xf_sat = 1'b0;
      xf.b1  = in1;
      xf.w3  = in3;
      for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
         xf.b2[i] = in2[i];
         xf.w4[i] = in4[i];
      end
      case (mode_e'(mode))
         INV: begin
            xf.b1 = ~in1;
            xf.w3 = ~in3;
            for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
               xf.b2[i] = ~in2[i];
               xf.w4[i] = ~in4[i];
            end
         end
         NEG: begin
            n      = sat_neg(WORD_MAX'(in3), DATA_WIDTH);
            xf.w3  = n.val[DATA_WIDTH-1:0];
            xf_sat = n.sat;
            for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
               n        = sat_neg(WORD_MAX'(in4[i]), DATA_WIDTH);
               xf.w4[i] = n.val[DATA_WIDTH-1:0];
               xf_sat   = xf_sat | n.sat;
            end
         end
         REV: begin
            for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
               xf.b2[i] = in2[BUS_WIDTH-1-i];
               xf.w4[i] = in4[BUS_WIDTH-1-i];
            end
         end
         default: ;
      endcase
   end

   // Index k is the input side of slice k; index DEPTH is the output side.
   logic  vld [DEPTH+1];
   logic  rdy [DEPTH+1];
   beat_t dat [DEPTH+1];

   assign vld[0]     = in_valid;
   assign dat[0]     = xf;
   assign rdy[DEPTH] = out_ready;
   assign in_ready   = !rst && rdy[0];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      dut_pipe_stage #(
         .beat_t (beat_t)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .up_valid (vld[k]),
         .up_data  (dat[k]),
         .up_ready (rdy[k]),
         .dn_valid (vld[k+1]),
         .dn_data  (dat[k+1]),
         .dn_ready (rdy[k+1])
      );
   end

   assign out_valid = vld[DEPTH];
   assign out1      = dat[DEPTH].b1;
   assign out3      = dat[DEPTH].w3;

   // Unpack the last slice into the unpacked output buses.
   always_comb begin
      for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
         out2[i] = dat[DEPTH].b2[i];
         out4[i] = dat[DEPTH].w4[i];
      end
   end

   // Count output handshakes and latch any saturation seen on an accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (in_valid && in_ready && xf_sat) begin
            sat_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dut_pipe.sv
// Self-checking bench for dut_pipe against a queue-based reference model.
`timescale 1ns/1ps
module tb_dut_pipe;

   localparam int unsigned DW    = 4;
   localparam int unsigned BW    = 2;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CW    = 4;
   localparam int          MAXV  = (1 << (DW - 1)) - 1;

   typedef struct packed {
      logic                   b1;
      logic [BW-1:0]          b2;
      logic signed [DW-1:0]   w3;
      logic [BW-1:0][DW-1:0]  w4;
   } beat_t;

   typedef struct {
      beat_t b;
      int    age;
   } ent_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [1:0]           mode = 2'd0;
   logic                 in1;
   logic                 in2 [BW];
   logic signed [DW-1:0] in3;
   logic signed [DW-1:0] in4 [BW];
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic                 out1;
   logic                 out2 [BW];
   logic signed [DW-1:0] out3;
   logic signed [DW-1:0] out4 [BW];
   logic [CW-1:0]        beat_cnt;
   logic                 sat_flag;

   beat_t cur;
   beat_t obs;
   ent_t  q[$];
   beat_t m_last;
   int    m_cnt;
   bit    m_sat;
   int    checks   = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   dut_pipe #(
      .DATA_WIDTH (DW),
      .BUS_WIDTH  (BW),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in4       (in4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out4      (out4),
      .beat_cnt  (beat_cnt),
      .sat_flag  (sat_flag)
   );

   always_comb begin
      obs.b1 = out1;
      obs.w3 = out3;
      for (int i = 0; i < BW; i++) begin
         obs.b2[i] = out2[i];
         obs.w4[i] = out4[i];
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [DW-1:0] neg_sat(input logic signed [DW-1:0] x, inout bit s);
      int v;
      v = -int'(x);
      if (v > MAXV) begin
         v = MAXV;
         s = 1'b1;
      end
      return DW'(v);
   endfunction

   function automatic beat_t xform(input logic [1:0] m, input beat_t b, inout bit s);
      beat_t r;
      r = b;
      case (m)
         2'd1: r = ~b;
         2'd2: begin
            r.w3 = neg_sat(b.w3, s);
            for (int i = 0; i < BW; i++) r.w4[i] = neg_sat(b.w4[i], s);
         end
         2'd3: begin
            for (int i = 0; i < BW; i++) begin
               r.b2[i] = b.b2[BW-1-i];
               r.w4[i] = b.w4[BW-1-i];
            end
         end
         default: ;
      endcase
      return r;
   endfunction

   // Head beat is visible once DEPTH-1 edges have passed since its acceptance.
   function automatic bit exp_ov();
      return q.size() > 0 && q[0].age >= int'(DEPTH) - 1;
   endfunction

   // Ready while below capacity, or when the full pipe can release a beat.
   function automatic bit exp_ir();
      return !rst && ((q.size() < int'(DEPTH)) || out_ready);
   endfunction

   task automatic model_edge();
      bit   ev, ir, s;
      ent_t e;
      if (rst) begin
         q.delete();
         m_cnt  = 0;
         m_sat  = 1'b0;
         m_last = '0;
         return;
      end
      ev = exp_ov();
      ir = exp_ir();
      if (ev && out_ready) begin
         void'(q.pop_front());
         m_cnt = (m_cnt + 1) % (1 << CW);
      end
      foreach (q[i]) q[i].age++;
      if (in_valid && ir) begin
         s     = 1'b0;
         e.b   = xform(mode, cur, s);
         e.age = 0;
         q.push_back(e);
         if (s) m_sat = 1'b1;
      end
      if (exp_ov()) m_last = q[0].b;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic beat_t rand_beat();
      logic [$bits(beat_t)-1:0] v;
      v = $bits(beat_t)'($urandom);
      return beat_t'(v);
   endfunction

   task automatic set_beat(input beat_t b, input logic [1:0] m, input logic v);
      cur      = b;
      mode     = m;
      in_valid = v;
      in1      = b.b1;
      in3      = b.w3;
      for (int i = 0; i < BW; i++) begin
         in2[i] = b.b2[i];
         in4[i] = b.w4[i];
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      set_beat(rand_beat(), 2'd2, 1'b1);
      repeat (3) tick();
      @(negedge clk);
      checks += 5;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (beat_cnt !== '0) begin failures++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
      if (obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
      if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat_flag got=%b exp=0", sat_flag); end
      tick();
   endtask

   task automatic test_pass_stream();
      beat_t         b;
      logic [DW-1:0] got[$];
      int            last_c = -1;
      do_reset(2);
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            b = rand_beat();
            b.w3 = DW'(c + 1);
            set_beat(b, 2'd0, 1'b1);
         end else in_valid = 1'b0;
         @(negedge clk);
         checks += 4;
         if (in_ready !== exp_ir()) begin failures++; $display("FAIL pass_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_ir()); end
         if (out_valid !== exp_ov()) begin failures++; $display("FAIL pass_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov()); end
         if (obs !== m_last) begin failures++; $display("FAIL pass_data c=%0d got=%h exp=%h", c, obs, m_last); end
         if (beat_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL pass_beat_cnt c=%0d got=%0d exp=%0d", c, beat_cnt, m_cnt); end
         if (c == 1 || c == 2) begin
            checks++;
            if (out_valid !== (c == 2)) begin failures++; $display("FAIL pass_latency c=%0d got=%b exp=%b", c, out_valid, c == 2); end
         end
         if (out_valid) begin
            got.push_back(out3);
            last_c = c;
         end
         tick();
      end
      checks += 3;
      if (got.size() != 8 || last_c != 9) begin failures++; $display("FAIL pass_no_bubbles got=%0d/%0d exp=8/9", got.size(), last_c); end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         if (got[i] !== DW'(i + 1)) begin failures++; $display("FAIL pass_order i=%0d got=%0d exp=%0d", i, got[i], i + 1); break; end
      end
      if (beat_cnt !== CW'(8)) begin failures++; $display("FAIL pass_final_cnt got=%0d exp=8", beat_cnt); end
   endtask

   task automatic test_neg_sat();
      beat_t b;
      int    nv = 0;
      do_reset(2);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         b = rand_beat();
         if (c == 0) begin
            b.w3 = 4'h8; b.w4[0] = 4'h8; b.w4[1] = 4'h3;
            set_beat(b, 2'd2, 1'b1);
         end else if (c < 4) begin
            b.w3 = 4'h1;
            set_beat(b, 2'd0, 1'b1);
         end else in_valid = 1'b0;
         @(negedge clk);
         checks += 3;
         if (out_valid !== exp_ov()) begin failures++; $display("FAIL neg_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov()); end
         if (obs !== m_last) begin failures++; $display("FAIL neg_data c=%0d got=%h exp=%h", c, obs, m_last); end
         if (sat_flag !== m_sat) begin failures++; $display("FAIL neg_sat_model c=%0d got=%b exp=%b", c, sat_flag, m_sat); end
         checks++;
         if (sat_flag !== (c >= 1)) begin failures++; $display("FAIL neg_sat_sticky c=%0d got=%b exp=%b", c, sat_flag, c >= 1); end
         if (out_valid) begin
            if (nv == 0) begin
               checks += 3;
               if (out3 !== 4'h7) begin failures++; $display("FAIL neg_out3 got=%h exp=7", out3); end
               if (out4[0] !== 4'h7) begin failures++; $display("FAIL neg_out4_0 got=%h exp=7", out4[0]); end
               if (out4[1] !== 4'hD) begin failures++; $display("FAIL neg_out4_1 got=%h exp=d", out4[1]); end
            end
            nv++;
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      beat_t beats[4];
      int    k = 0;
      int    acc = 0;
      beat_t held;
      do_reset(2);
      out_ready = 1'b0;
      foreach (beats[i]) beats[i] = rand_beat();
      for (int c = 0; c < 5; c++) begin
         set_beat(beats[k], 2'd0, 1'b1);
         @(negedge clk);
         checks += 3;
         if (in_ready !== exp_ir()) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_ir()); end
         if (out_valid !== exp_ov()) begin failures++; $display("FAIL bp_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov()); end
         if (obs !== m_last) begin failures++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, obs, m_last); end
         if (c == 2) held = obs;
         if (c > 2) begin
            checks++;
            if (obs !== held) begin failures++; $display("FAIL bp_stable c=%0d got=%h exp=%h", c, obs, held); end
         end
         if (in_valid && in_ready) acc++;
         tick();
         if (acc > k) k = acc;
      end
      checks += 2;
      if (acc != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", acc); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks += 2;
         if (out_valid !== (c < 2)) begin failures++; $display("FAIL bp_drain_valid c=%0d got=%b exp=%b", c, out_valid, c < 2); end
         if (c < 2 && obs !== beats[c]) begin failures++; $display("FAIL bp_drain_data c=%0d got=%h exp=%h", c, obs, beats[c]); end
         tick();
      end
      checks++;
      if (beat_cnt !== CW'(2)) begin failures++; $display("FAIL bp_beat_cnt got=%0d exp=2", beat_cnt); end
   endtask

   task automatic test_inv_rev();
      beat_t b;
      int    nv = 0;
      do_reset(2);
      out_ready = 1'b1;
      b = rand_beat();
      b.b1 = 1'b1; b.b2[0] = 1'b1; b.b2[1] = 1'b0;
      b.w4[0] = 4'h2; b.w4[1] = 4'hB;
      for (int c = 0; c < 5; c++) begin
         if (c == 0) set_beat(b, 2'd1, 1'b1);
         else if (c == 1) set_beat(b, 2'd3, 1'b1);
         else in_valid = 1'b0;
         @(negedge clk);
         checks += 2;
         if (out_valid !== exp_ov()) begin failures++; $display("FAIL ir_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov()); end
         if (obs !== m_last) begin failures++; $display("FAIL ir_data c=%0d got=%h exp=%h", c, obs, m_last); end
         if (out_valid && nv == 0) begin
            checks += 4;
            if (out1 !== 1'b0) begin failures++; $display("FAIL inv_out1 got=%b exp=0", out1); end
            if (out2[0] !== 1'b0 || out2[1] !== 1'b1) begin failures++; $display("FAIL inv_out2 got=%b%b exp=10", out2[1], out2[0]); end
            if (out4[0] !== 4'hD) begin failures++; $display("FAIL inv_out4_0 got=%h exp=d", out4[0]); end
            if (out4[1] !== 4'h4) begin failures++; $display("FAIL inv_out4_1 got=%h exp=4", out4[1]); end
         end else if (out_valid && nv == 1) begin
            checks += 4;
            if (out1 !== 1'b1) begin failures++; $display("FAIL rev_out1 got=%b exp=1", out1); end
            if (out2[0] !== 1'b0 || out2[1] !== 1'b1) begin failures++; $display("FAIL rev_out2 got=%b%b exp=10", out2[1], out2[0]); end
            if (out4[0] !== 4'hB) begin failures++; $display("FAIL rev_out4_0 got=%h exp=b", out4[0]); end
            if (out4[1] !== 4'h2) begin failures++; $display("FAIL rev_out4_1 got=%h exp=2", out4[1]); end
         end
         if (out_valid) nv++;
         tick();
      end
      checks++;
      if (nv != 2) begin failures++; $display("FAIL ir_count got=%0d exp=2", nv); end
   endtask

   task automatic test_reset_mid_wrap();
      rst = 1'b0;
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         set_beat(rand_beat(), 2'($urandom_range(0, 3)), 1'b1);
         tick();
      end
      do_reset(1);
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale c=%0d got=%b exp=0", c, out_valid); end
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         if (c < 17) set_beat(rand_beat(), 2'd0, 1'b1);
         else in_valid = 1'b0;
         @(negedge clk);
         checks += 2;
         if (obs !== m_last) begin failures++; $display("FAIL wrap_data c=%0d got=%h exp=%h", c, obs, m_last); end
         if (beat_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL wrap_cnt_model c=%0d got=%0d exp=%0d", c, beat_cnt, m_cnt); end
         tick();
      end
      checks++;
      if (beat_cnt !== CW'(1)) begin failures++; $display("FAIL wrap_beat_cnt got=%0d exp=1", beat_cnt); end
   endtask

   task automatic test_random();
      do_reset(2);
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 63) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         set_beat(rand_beat(), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
         @(negedge clk);
         checks += 5;
         if (in_ready !== exp_ir()) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_ir()); end
         if (out_valid !== exp_ov()) begin failures++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov()); end
         if (obs !== m_last) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, obs, m_last); end
         if (beat_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL rnd_beat_cnt c=%0d got=%0d exp=%0d", c, beat_cnt, m_cnt); end
         if (sat_flag !== m_sat) begin failures++; $display("FAIL rnd_sat_flag c=%0d got=%b exp=%b", c, sat_flag, m_sat); end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      set_beat('0, 2'd0, 1'b0);
      test_reset();
      test_pass_stream();
      test_neg_sat();
      test_backpressure();
      test_inv_rev();
      test_reset_mid_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
